mult_sequencer: RTL and testbench

Cycle-level sequencer for the signed add-shift multiplier datapath (X/A/B registers plus 9-bit adder). It accepts the synchronized Run and ClearA_LoadB push-button levels and emits the one-hot-per-cycle control strobes: clear, load, add, subtract and shift. It runs exactly WIDTH add/shift iterations per multiply, with a subtract on the final iteration for two's-complement correction. It then parks in a done state until Run is released, so a held button never re-triggers a multiply.

---
 rtl/mult_sequencer.sv | 78 +++++++
 tb/tb_mult_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Control sequencer for the signed add-shift multiplier: decodes push-button
// levels into per-cycle clear/load/add/subtract/shift strobes for WIDTH iterations.
module mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Run,
  input  logic                     ClearA_LoadB,
  input  logic                     M,
  output logic                     Clear_XA,
  output logic                     Ld_B,
  output logic                     Add_En,
  output logic                     Sub_En,
  output logic                     Shift_En,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(WIDTH)-1:0] Count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLR   = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] count;
  logic          last_iter;

  assign last_iter = (count == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // A held load button blocks the multiply from starting.
        if (ClearA_LoadB)
          state_nxt = IDLE;
        else if (Run)
          state_nxt = CLR;
      end
      CLR:   state_nxt = ADD;
      ADD:   state_nxt = SHIFT;
      SHIFT: state_nxt = last_iter ? DONE : ADD;
      DONE:  state_nxt = Run ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLR)
        count <= '0;
      else if (state == SHIFT && !last_iter)
        count <= count + CW'(1);
    end
  end

  // The final iteration subtracts to correct for the multiplier's sign weight.
  assign Clear_XA = ((state == IDLE) && ClearA_LoadB) || (state == CLR);
  assign Ld_B     = (state == IDLE) && ClearA_LoadB;
  assign Add_En   = (state == ADD) && M && !last_iter;
  assign Sub_En   = (state == ADD) && M && last_iter;
  assign Shift_En = (state == SHIFT);
  assign Busy     = (state == CLR) || (state == ADD) || (state == SHIFT);
  assign Done     = (state == DONE);
  assign Count    = count;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: fixed vector table, hand-built
// multi-cycle sequences and random stimulus against a schedule-based model.
module tb_mult_sequencer;

  localparam int W  = 8;
  localparam int CW = $clog2(W);
  localparam int VW = 7 + CW;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Run;
  logic          ClearA_LoadB;
  logic          M;
  logic          Clear_XA, Ld_B, Add_En, Sub_En, Shift_En, Busy, Done;
  logic [CW-1:0] Count;

  mult_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clear_XA(Clear_XA), .Ld_B(Ld_B), .Add_En(Add_En), .Sub_En(Sub_En),
    .Shift_En(Shift_En), .Busy(Busy), .Done(Done), .Count(Count)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 multiplying, 2 done. While multiplying, step 0 is
  // the clear cycle and steps 1..2W alternate add (odd) and shift (even).
  int ph   = 0;
  int step = 0;
  int mcnt = 0;
  int cyc  = 0;
  int n_add, n_sub, n_shift, n_clr, done_cyc;

  typedef struct {
    logic          run;
    logic          clb;
    logic          m;
    logic [VW-1:0] exp;
    string         name;
  } vec_t;

  function automatic logic [VW-1:0] dut_vec();
    return {Clear_XA, Ld_B, Add_En, Sub_En, Shift_En, Busy, Done, Count};
  endfunction

  function automatic logic [VW-1:0] model_out(input logic clb, input logic m);
    logic clr, ld, ad, sb, sh, bs, dn;
    int   it;
    int   cnt;
    {clr, ld, ad, sb, sh, bs, dn} = '0;
    cnt = mcnt;
    if (ph == 0) begin
      clr = clb;
      ld  = clb;
    end else if (ph == 1) begin
      bs = 1'b1;
      if (step == 0) begin
        clr = 1'b1;
      end else begin
        it  = (step - 1) / 2;
        cnt = it;
        if (step % 2 == 1) begin
          ad = m && (it < W - 1);
          sb = m && (it == W - 1);
        end else begin
          sh = 1'b1;
        end
      end
    end else begin
      dn  = 1'b1;
      cnt = W - 1;
    end
    return {clr, ld, ad, sb, sh, bs, dn, CW'(cnt)};
  endfunction

  task automatic model_adv(input logic run, input logic clb);
    if (ph == 0) begin
      if (!clb && run) begin
        ph   = 1;
        step = 0;
      end
    end else if (ph == 1) begin
      if (step == 2 * W) begin
        ph   = 2;
        mcnt = W - 1;
      end else begin
        step = step + 1;
        mcnt = (step - 1) / 2;
      end
    end else if (!run) begin
      ph = 0;
    end
  endtask

  task automatic model_reset();
    ph   = 0;
    step = 0;
    mcnt = 0;
  endtask

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Called just after a rising edge: drive, compare at the falling edge, advance.
  task automatic cycle_chk(input logic run, input logic clb, input logic m,
                           input logic use_exp, input logic [VW-1:0] exp, input string name);
    Run = run;
    ClearA_LoadB = clb;
    M = m;
    #4;
    check(name, dut_vec(), use_exp ? exp : model_out(clb, m));
    if (Add_En) n_add++;
    if (Sub_En) n_sub++;
    if (Shift_En) n_shift++;
    if (Clear_XA && Busy) n_clr++;
    if (Done && done_cyc < 0) done_cyc = cyc;
    @(posedge Clk);
    model_adv(run, clb);
    cyc++;
    #1;
  endtask

  task automatic clear_stats();
    n_add = 0; n_sub = 0; n_shift = 0; n_clr = 0; done_cyc = -1;
  endtask

  function automatic logic m_for(input logic [W-1:0] pat);
    if (ph == 1 && step % 2 == 1) return pat[(step - 1) / 2];
    return 1'b0;
  endfunction

  vec_t vt[11];
  int   c0;
  logic [W-1:0] pat;

  initial begin
    //            run  clb  m     {clr,ld,add,sub,sh,busy,done}, count
    vt[0]  = '{1'b0, 1'b1, 1'b0, {7'b1100000, 3'd0}, "load0"};
    vt[1]  = '{1'b0, 1'b1, 1'b0, {7'b1100000, 3'd0}, "load1"};
    vt[2]  = '{1'b0, 1'b1, 1'b0, {7'b1100000, 3'd0}, "load2"};
    vt[3]  = '{1'b1, 1'b1, 1'b0, {7'b1100000, 3'd0}, "load_beats_run"};
    vt[4]  = '{1'b0, 1'b0, 1'b0, {7'b0000000, 3'd0}, "idle_no_clr"};
    vt[5]  = '{1'b1, 1'b0, 1'b0, {7'b0000000, 3'd0}, "idle_run"};
    vt[6]  = '{1'b0, 1'b1, 1'b1, {7'b1000010, 3'd0}, "clr_ignores_load"};
    vt[7]  = '{1'b0, 1'b0, 1'b1, {7'b0010010, 3'd0}, "add_it0"};
    vt[8]  = '{1'b0, 1'b0, 1'b1, {7'b0000110, 3'd0}, "shift_it0"};
    vt[9]  = '{1'b0, 1'b0, 1'b0, {7'b0000010, 3'd1}, "add_it1_m0"};
    vt[10] = '{1'b0, 1'b0, 1'b0, {7'b0000110, 3'd1}, "shift_it1"};

    clear_stats();
    // Reset with Run high: outputs at zero, no start while held.
    Reset = 1'b0; Run = 1'b1; ClearA_LoadB = 1'b0; M = 1'b0;
    repeat (2) @(posedge Clk);
    #4;
    check("reset_outputs", dut_vec(), '0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    model_reset();
    cycle_chk(1'b1, 1'b0, 1'b0, 1'b0, '0, "reset_release");
    #4;
    check("clr_after_release", dut_vec(), {7'b1000010, 3'd0});
    // Back to a known IDLE for the vector table.
    Reset = 1'b0; #1; Reset = 1'b1; Run = 1'b0;
    model_reset();
    @(posedge Clk); #1;

    for (int i = 0; i < 11; i++)
      cycle_chk(vt[i].run, vt[i].clb, vt[i].m, 1'b1, vt[i].exp, vt[i].name);

    // Run on to SHIFT at Count=4, then assert reset asynchronously.
    for (int i = 0; i < 40 && !(ph == 1 && step == 10); i++)
      cycle_chk(1'b0, 1'b0, 1'b1, 1'b0, '0, "run_to_shift4");
    #2;
    check("pre_reset_shift4", dut_vec(), {7'b0000110, 3'd4});
    Reset = 1'b0;
    #1;
    check("async_reset_mid_op", dut_vec(), '0);
    model_reset();
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;

    // Full multiply with M=1 on every add.
    clear_stats();
    c0 = cyc;
    cycle_chk(1'b1, 1'b0, 1'b0, 1'b0, '0, "m1_start");
    for (int i = 0; i < 2 * W + 3; i++)
      cycle_chk(1'b0, 1'b0, 1'b1, 1'b0, '0, "m1_run");
    check_int("m1_adds", n_add, W - 1);
    check_int("m1_subs", n_sub, 1);
    check_int("m1_shifts", n_shift, W);
    check_int("m1_done_latency", done_cyc - c0, 2 * W + 2);

    // M pattern 1,0,1,0,0,0,0,0 presented per iteration.
    clear_stats();
    pat = 8'b0000_0101;
    c0 = cyc;
    cycle_chk(1'b1, 1'b0, 1'b0, 1'b0, '0, "pat_start");
    for (int i = 0; i < 2 * W + 3; i++)
      cycle_chk(1'b0, 1'b0, m_for(pat), 1'b0, '0, "pat_run");
    check_int("pat_adds", n_add, 2);
    check_int("pat_subs", n_sub, 0);
    check_int("pat_done_latency", done_cyc - c0, 2 * W + 2);

    // Held Run for 40 cycles, with a load pulse during SHIFT at Count=3.
    clear_stats();
    c0 = cyc;
    for (int i = 0; i < 40; i++)
      cycle_chk(1'b1, (ph == 1 && step == 8), $urandom_range(0, 1) == 1, 1'b0, '0, "held_run");
    check_int("held_one_clear", n_clr, 1);
    check_int("held_shifts", n_shift, W);
    check_int("held_done_latency", done_cyc - c0, 2 * W + 2);
    cycle_chk(1'b0, 1'b0, 1'b0, 1'b0, '0, "held_drop_done");
    cycle_chk(1'b1, 1'b0, 1'b0, 1'b0, '0, "rerun_idle");
    cycle_chk(1'b0, 1'b0, 1'b0, 1'b0, '0, "rerun_clr");

    // Random stimulus.
    for (int i = 0; i < 600; i++)
      cycle_chk($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 1, 1'b0, '0, "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
